ldtu_ham_decoder: RTL and testbench

Output-side Hamming decoder stage of the LiTe-DTU readout chain, sitting directly downstream of the output storage FIFO. It pops 38-bit Hamming(38,32) words from the FIFO with a read-request state machine and corrects single-bit errors. It flags words whose syndrome points outside the codeword and presents 32-bit payloads to the serializer with a valid/ready handshake. Optional saturating error counters provide radiation/SEU monitoring.

---
 rtl/ldtu_ham_decoder_if.sv | 37 +++
 rtl/ldtu_ham_decoder.sv | 152 +++++++++++++++
 tb/tb_ldtu_ham_decoder.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ldtu_ham_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : ldtu_ham_decoder_if
// Purpose  : FIFO-side and serializer-side signal bundle of ldtu_ham_decoder
// Revision : 1.0 - initial release
// ============================================================================
interface ldtu_ham_decoder_if #(
    parameter int Nbits_ham  = 38,
    parameter int Nbits_data = 32,
    parameter int Ncnt       = 8
);
    logic                  empty_signal;
    logic                  decode_signal;
    logic [Nbits_ham-1:0]  data_input;
    logic                  read_signal;
    logic                  data_ready;
    logic [Nbits_data-1:0] data_out;
    logic                  data_valid;
    logic                  err_single;
    logic                  err_uncorr;
    logic                  cnt_clear;
    logic [Ncnt-1:0]       cnt_single;
    logic [Ncnt-1:0]       cnt_uncorr;

    modport master (
        input  empty_signal, decode_signal, data_input, data_ready, cnt_clear,
        output read_signal, data_out, data_valid, err_single, err_uncorr,
               cnt_single, cnt_uncorr
    );

    modport slave (
        output empty_signal, decode_signal, data_input, data_ready, cnt_clear,
        input  read_signal, data_out, data_valid, err_single, err_uncorr,
               cnt_single, cnt_uncorr
    );
endinterface
`default_nettype wire

// File: rtl/ldtu_ham_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ldtu_ham_decoder
// Purpose  : Pops Hamming(38,32) words from the output FIFO, corrects single
//            errors and hands 32-bit payloads to the serializer.
//            Optional error counters: define LDTU_DEC_ERRCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ldtu_ham_decoder #(
    parameter int Nbits_ham  = 38,
    parameter int Nbits_data = 32,
    parameter int Ncnt       = 8
) (
    input  wire logic           CLK,
    input  wire logic           rst_b,
    ldtu_ham_decoder_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_read;
    logic                  r_valid;
    logic [Nbits_data-1:0] r_data;
    logic                  r_single;
    logic                  r_uncorr;

    logic [5:0]            w_syndrome;
    logic                  w_single;
    logic                  w_uncorr;
    logic [Nbits_ham-1:0]  w_corrected;
    logic [Nbits_data-1:0] w_payload;
    logic [4:0]            w_idx;
    logic                  w_load;

    // Bit i sits at Hamming position i+1, so the syndrome is the XOR of set positions
    always_comb begin
        w_syndrome = '0;
        for (int i = 0; i < Nbits_ham; i++) begin
            if (bus.data_input[i]) begin
                w_syndrome = w_syndrome ^ 6'(i + 1);
            end
        end
    end

    always_comb begin
        w_single    = (w_syndrome != 6'd0) && (w_syndrome <= 6'(Nbits_ham));
        w_uncorr    = (w_syndrome > 6'(Nbits_ham));
        w_corrected = bus.data_input;
        for (int i = 0; i < Nbits_ham; i++) begin
            if (w_single && (w_syndrome == 6'(i + 1))) begin
                w_corrected[i] = ~bus.data_input[i];
            end
        end
        // Non-power-of-two positions, ascending, form the payload
        w_payload = '0;
        w_idx     = '0;
        for (int p = 1; p <= Nbits_ham; p++) begin
            if ((p & (p - 1)) != 0) begin
                w_payload[w_idx] = w_corrected[p-1];
                w_idx            = w_idx + 5'd1;
            end
        end
    end

    assign w_load = (r_state == S_WAIT) && bus.decode_signal;

    always_ff @(posedge CLK) begin
        if (!rst_b) begin
            r_state  <= S_IDLE;
            r_read   <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_single <= 1'b0;
            r_uncorr <= 1'b0;
        end else begin
            r_read <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!bus.empty_signal) begin
                        r_state <= S_REQ;
                        r_read  <= 1'b1;
                    end
                end
                S_REQ: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A missing acknowledge drops the pop and retries from IDLE
                    if (bus.decode_signal) begin
                        r_state  <= S_HOLD;
                        r_valid  <= 1'b1;
                        r_data   <= w_payload;
                        r_single <= w_single;
                        r_uncorr <= w_uncorr;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (bus.data_ready) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.read_signal = r_read;
    assign bus.data_valid  = r_valid;
    assign bus.data_out    = r_data;
    assign bus.err_single  = r_single;
    assign bus.err_uncorr  = r_uncorr;

`ifdef LDTU_DEC_ERRCNT_EN
    logic [Ncnt-1:0] r_cnt_single;
    logic [Ncnt-1:0] r_cnt_uncorr;

    always_ff @(posedge CLK) begin
        if (!rst_b || bus.cnt_clear) begin
            r_cnt_single <= '0;
            r_cnt_uncorr <= '0;
        end else if (w_load) begin
            if (w_single && (r_cnt_single != '1)) begin
                r_cnt_single <= r_cnt_single + Ncnt'(1);
            end
            if (w_uncorr && (r_cnt_uncorr != '1)) begin
                r_cnt_uncorr <= r_cnt_uncorr + Ncnt'(1);
            end
        end
    end

    assign bus.cnt_single = r_cnt_single;
    assign bus.cnt_uncorr = r_cnt_uncorr;
`else
    logic w_unused_cnt_clear;
    assign w_unused_cnt_clear = bus.cnt_clear;
    assign bus.cnt_single     = '0;
    assign bus.cnt_uncorr     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ldtu_ham_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ldtu_ham_decoder
// Purpose  : Directed self-checking bench for ldtu_ham_decoder with FIFO model
// Revision : 1.0 - initial release
// ============================================================================
module tb_ldtu_ham_decoder;

`ifdef LDTU_DEC_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam int CMAX = 255;

    typedef struct {
        logic [37:0] word;
        logic [31:0] data;
        logic        s;
        logic        u;
        logic        clr;
    } item_t;

    logic CLK = 1'b0;
    logic rst_b = 1'b0;
    always #5 CLK = ~CLK;

    ldtu_ham_decoder_if bus ();
    ldtu_ham_decoder dut (.CLK(CLK), .rst_b(rst_b), .bus(bus));

    item_t fifo_q[$];
    item_t sb_q[$];
    item_t drv_it;
    item_t cmp_it;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    m_cs    = 0;
    int    m_cu    = 0;
    bit    auto_en = 1'b0;
    bit    pend_read = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    function automatic logic [37:0] encode(input logic [31:0] d);
        logic [37:0] w;
        logic        par;
        int          k;
        w = '0;
        k = 0;
        for (int p = 1; p <= 38; p++) begin
            if (!is_pow2(p)) begin
                w[p-1] = d[k];
                k++;
            end
        end
        for (int b = 0; b < 6; b++) begin
            par = 1'b0;
            for (int p = 1; p <= 38; p++) begin
                if (!is_pow2(p) && (((p >> b) & 1) == 1)) par = par ^ w[p-1];
            end
            w[(1 << b) - 1] = par;
        end
        return w;
    endfunction

    function automatic logic [31:0] extract(input logic [37:0] w);
        logic [31:0] d;
        int          k;
        d = '0;
        k = 0;
        for (int p = 1; p <= 38; p++) begin
            if (!is_pow2(p)) begin
                d[k] = w[p-1];
                k++;
            end
        end
        return d;
    endfunction

    // A clean codeword has zero syndrome, so only the flipped positions matter
    function automatic item_t mk(input logic [31:0] d, input logic [37:0] mask, input logic clr);
        item_t       it;
        int          s;
        logic [37:0] cm;
        s = 0;
        for (int p = 1; p <= 38; p++) if (mask[p-1]) s = s ^ p;
        cm = mask;
        if (s >= 1 && s <= 38) cm[s-1] = ~cm[s-1];
        it.word = encode(d) ^ mask;
        it.data = d ^ extract(cm);
        it.s    = (s >= 1 && s <= 38);
        it.u    = (s > 38);
        it.clr  = clr;
        return it;
    endfunction

    function automatic item_t mkl(input logic [37:0] w, input logic [31:0] d, input logic s, input logic u);
        item_t it;
        it.word = w;
        it.data = d;
        it.s    = s;
        it.u    = u;
        it.clr  = 1'b0;
        return it;
    endfunction

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (!(fifo_q.size() == 0 && sb_q.size() == 0 && !bus.data_valid) && k < budget) begin
            @(negedge CLK);
            #2;
            k++;
        end
        if (k >= budget) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d words pending, required 0", fifo_q.size() + sb_q.size());
        end
    endtask

    // FIFO model: answers a pop one cycle after read_signal is seen
    initial begin
        forever begin
            @(negedge CLK);
            if (auto_en) begin
                bus.decode_signal = 1'b0;
                bus.cnt_clear     = 1'b0;
                if (pend_read && fifo_q.size() > 0) begin
                    drv_it            = fifo_q.pop_front();
                    bus.data_input    = drv_it.word;
                    bus.decode_signal = 1'b1;
                    bus.cnt_clear     = drv_it.clr;
                    sb_q.push_back(drv_it);
                end
                pend_read        = bus.read_signal;
                bus.empty_signal = (fifo_q.size() == 0);
            end
        end
    end

    // Compare process
    initial begin
        int          cyc, rc;
        bit          prev_read, prev_valid, stall;
        logic [31:0] sd;
        logic        ss, su;
        cyc = 0; rc = -100; prev_read = 0; prev_valid = 0; stall = 0;
        sd = '0; ss = 0; su = 0;
        forever begin
            @(negedge CLK);
            #1;
            cyc++;
            if (!rst_b) begin
                prev_read = 0; prev_valid = 0; stall = 0; rc = -100;
                continue;
            end
            if (bus.read_signal) begin
                if (prev_read) chk("read_single_cycle", 64'(prev_read && bus.read_signal), 64'd0);
                rc = cyc;
            end
            if (bus.data_valid && !prev_valid) chk("pop_to_valid", 64'(cyc), 64'(rc + 2));
            if (bus.data_valid) chk("no_req_while_valid", 64'(bus.read_signal), 64'd0);
            if (stall) begin
                chk("stall_valid", 64'(bus.data_valid), 64'd1);
                chk("stall_data", 64'(bus.data_out), 64'(sd));
                chk("stall_flags", {62'd0, bus.err_single, bus.err_uncorr}, {62'd0, ss, su});
            end
            stall = bus.data_valid && !bus.data_ready;
            sd = bus.data_out; ss = bus.err_single; su = bus.err_uncorr;
            if (bus.data_valid && bus.data_ready) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got data_out 0x%0h, required no word", bus.data_out);
                end else begin
                    cmp_it = sb_q.pop_front();
                    if (cmp_it.clr) begin
                        m_cs = 0; m_cu = 0;
                    end else begin
                        if (cmp_it.s && m_cs < CMAX) m_cs++;
                        if (cmp_it.u && m_cu < CMAX) m_cu++;
                    end
                    chk("data_out", 64'(bus.data_out), 64'(cmp_it.data));
                    chk("err_single", 64'(bus.err_single), 64'(cmp_it.s));
                    chk("err_uncorr", 64'(bus.err_uncorr), 64'(cmp_it.u));
                    chk("cnt_single", 64'(bus.cnt_single), CNT_EN ? 64'(m_cs) : 64'd0);
                    chk("cnt_uncorr", 64'(bus.cnt_uncorr), CNT_EN ? 64'(m_cu) : 64'd0);
                end
            end
            prev_read  = bus.read_signal;
            prev_valid = bus.data_valid;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        bus.empty_signal  = 1'b1;
        bus.decode_signal = 1'b0;
        bus.data_input    = '0;
        bus.data_ready    = 1'b1;
        bus.cnt_clear     = 1'b0;
        rst_b             = 1'b0;
        repeat (3) @(negedge CLK);
        #2;
        chk("rst_read", 64'(bus.read_signal), 64'd0);
        chk("rst_valid", 64'(bus.data_valid), 64'd0);
        chk("rst_data", 64'(bus.data_out), 64'd0);
        chk("rst_flags", {62'd0, bus.err_single, bus.err_uncorr}, 64'd0);
        chk("rst_cnts", {48'd0, bus.cnt_single, bus.cnt_uncorr}, 64'd0);
        chk("enc_pin_lsb", 64'(encode(32'h1)), 64'h7);
        chk("enc_pin_msb", 64'(encode(32'h8000_0000)), 64'h20_8000_000A);

        @(negedge CLK);
        rst_b   = 1'b1;
        auto_en = 1'b1;

        // All-zero word: pop timing
        @(negedge CLK); #2;
        fifo_q.push_back(mkl(38'h0, 32'h0, 1'b0, 1'b0));
        @(negedge CLK); #2;
        chk("empty_fall", 64'(bus.empty_signal), 64'd0);
        chk("read_early", 64'(bus.read_signal), 64'd0);
        @(negedge CLK); #2;
        chk("read_pulse", 64'(bus.read_signal), 64'd1);
        @(negedge CLK); #2;
        chk("valid_early", 64'(bus.data_valid), 64'd0);
        @(negedge CLK); #2;
        chk("valid_at_lat", 64'(bus.data_valid), 64'd1);
        chk("dout_zero", 64'(bus.data_out), 64'd0);
        wait_drain(20);

        fifo_q.push_back(mkl(38'h4, 32'h0, 1'b1, 1'b0));
        wait_drain(20);
        chk("cnt_single_one", 64'(bus.cnt_single), CNT_EN ? 64'd1 : 64'd0);

        fifo_q.push_back(mkl(38'h8000_0040, 32'h8, 1'b0, 1'b1));
        wait_drain(20);
        chk("cnt_uncorr_one", 64'(bus.cnt_uncorr), CNT_EN ? 64'd1 : 64'd0);

        fifo_q.push_back(mk(32'hDEAD_BEEF, 38'h0, 1'b0));
        fifo_q.push_back(mk(32'hA5A5_5A5A, 38'h1, 1'b0));
        fifo_q.push_back(mk(32'h0F0F_F0F0, 38'h20_0000_0000, 1'b0));
        fifo_q.push_back(mk(32'h1357_9BDF, 38'h7, 1'b0));
        fifo_q.push_back(mk(32'hCAFE_F00D, 38'h2_0000_0010, 1'b0));
        fifo_q.push_back(mk(32'h7654_3210, 38'hC000_0000, 1'b0));
        wait_drain(60);

        // Backpressure: ready low for 5 cycles with words queued
        @(negedge CLK);
        bus.data_ready = 1'b0;
        for (int i = 0; i < 3; i++) fifo_q.push_back(mk($urandom, 38'd1 << $urandom_range(37, 0), 1'b0));
        k = 0;
        while (!bus.data_valid && k < 20) begin
            @(negedge CLK); #2; k++;
        end
        chk("stall_valid_seen", 64'(bus.data_valid), 64'd1);
        repeat (5) @(negedge CLK);
        #2;
        chk("stall_no_read", 64'(bus.read_signal), 64'd0);
        @(negedge CLK);
        bus.data_ready = 1'b1;
        wait_drain(60);

        // Saturation then clear coinciding with an increment
        for (int i = 0; i < 260; i++) fifo_q.push_back(mk($urandom, 38'd1 << $urandom_range(37, 0), 1'b0));
        wait_drain(260 * 4 + 60);
        chk("cnt_single_sat", 64'(bus.cnt_single), CNT_EN ? 64'd255 : 64'd0);
        fifo_q.push_back(mk(32'h5555_AAAA, 38'd1 << 20, 1'b1));
        wait_drain(20);
        chk("cnt_clear_single", 64'(bus.cnt_single), 64'd0);
        chk("cnt_clear_uncorr", 64'(bus.cnt_uncorr), 64'd0);

        fifo_q.push_back(mk(32'h1234_5678, 38'd1 << 10, 1'b0));
        wait_drain(20);

        // Reset while the pop is in WAIT
        auto_en = 1'b0;
        @(negedge CLK);
        bus.empty_signal  = 1'b0;
        bus.decode_signal = 1'b0;
        bus.cnt_clear     = 1'b0;
        @(negedge CLK); #2;
        chk("rst_test_read", 64'(bus.read_signal), 64'd1);
        bus.empty_signal = 1'b1;
        @(negedge CLK);
        rst_b = 1'b0;
        @(negedge CLK); #2;
        chk("midrst_read", 64'(bus.read_signal), 64'd0);
        chk("midrst_valid", 64'(bus.data_valid), 64'd0);
        chk("midrst_data", 64'(bus.data_out), 64'd0);
        chk("midrst_flags", {62'd0, bus.err_single, bus.err_uncorr}, 64'd0);
        chk("midrst_cnts", {48'd0, bus.cnt_single, bus.cnt_uncorr}, 64'd0);
        rst_b             = 1'b1;
        bus.decode_signal = 1'b1;
        bus.data_input    = encode(32'hFFFF_0000);
        m_cs = 0;
        m_cu = 0;
        @(negedge CLK);
        bus.decode_signal = 1'b0;
        #2;
        chk("late_ack_valid", 64'(bus.data_valid), 64'd0);
        chk("late_ack_read", 64'(bus.read_signal), 64'd0);
        @(negedge CLK); #2;
        chk("idle_hold_valid", 64'(bus.data_valid), 64'd0);
        chk("idle_hold_read", 64'(bus.read_signal), 64'd0);
        pend_read = 1'b0;
        auto_en   = 1'b1;
        fifo_q.push_back(mk(32'h0BAD_CAFE, 38'd1 << 35, 1'b0));
        wait_drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
